// File: rtl/box_pkg.sv
// Shared constants for the box animation datapath.
package box_pkg;
  localparam int BOX_SIZE = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam logic [CW-1:0] COLOUR_BLACK = 3'b000;
  localparam logic [3:0] LAST_PIX = 4'(BOX_SIZE * BOX_SIZE - 1);
endpackage

// File: rtl/box_datapath_frame_timer.sv
// Wait-interval counter; expire marks the last tick of a frame interval.
module frame_timer #(
  parameter int FRAME_TICKS = 833333
) (
  input  logic clock,
  input  logic resetn,
  input  logic count_en,
  output logic expire
);
  localparam int W = (FRAME_TICKS > 2) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [W-1:0] LAST = W'(FRAME_TICKS - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (count_en)
      cnt_d = expire ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/box_datapath.sv
// 4x4 box draw/erase sweep, frame wait and per-frame position step.
// Define BOX_DATAPATH_BOUNCE_EN to bounce off the edges instead of wrapping.
module box_datapath
  import box_pkg::*;
#(
  parameter int X_MAX       = 160,
  parameter int Y_MAX       = 120,
  parameter int FRAME_TICKS = 833333
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          en_datapath,
  input  logic          en_vga,
  input  logic          erase,
  input  logic          can_move,
  input  logic [CW-1:0] colour_in,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour,
  output logic          plot,
  output logic          done
);
  localparam logic [XW-1:0] X_LAST = XW'(X_MAX - BOX_SIZE);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_MAX - BOX_SIZE);

  logic [3:0]    count_q, count_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          last, step, expire;

  frame_timer #(
    .FRAME_TICKS(FRAME_TICKS)
  ) u_timer (
    .clock   (clock),
    .resetn  (resetn),
    .count_en(~en_datapath & ~erase & can_move),
    .expire  (expire)
  );

  assign last   = (count_q == LAST_PIX);
  assign step   = en_datapath & erase & last;
  assign x      = x_q + XW'(count_q[1:0]);
  assign y      = y_q + YW'(count_q[3:2]);
  assign colour = erase ? COLOUR_BLACK : colour_in;
  assign plot   = en_vga & en_datapath & resetn;
  assign count_d = en_datapath ? count_q + 4'd1 : 4'd0;

  always_comb begin
    done = 1'b0;
    if (resetn) begin
      if (en_datapath)  done = last;
      else if (!erase)  done = ~expire;
    end
  end

`ifdef BOX_DATAPATH_BOUNCE_EN
  logic dx_q, dx_d, dy_q, dy_d;

  always_comb begin
    x_d  = x_q;
    dx_d = dx_q;
    y_d  = y_q;
    dy_d = dy_q;
    if (step) begin
      if (dx_q && x_q == X_LAST) begin
        dx_d = 1'b0;
        x_d  = x_q - 1'b1;
      end else if (!dx_q && x_q == '0) begin
        dx_d = 1'b1;
        x_d  = x_q + 1'b1;
      end else begin
        x_d = dx_q ? x_q + 1'b1 : x_q - 1'b1;
      end
      if (dy_q && y_q == Y_LAST) begin
        dy_d = 1'b0;
        y_d  = y_q - 1'b1;
      end else if (!dy_q && y_q == '0) begin
        dy_d = 1'b1;
        y_d  = y_q + 1'b1;
      end else begin
        y_d = dy_q ? y_q + 1'b1 : y_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dx_q <= 1'b1;
      dy_q <= 1'b1;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end
`else
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (step) begin
      x_d = (x_q == X_LAST) ? '0 : x_q + 1'b1;
      y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      count_q <= count_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end
endmodule

// File: tb/tb_box_datapath.sv
// Scoreboard bench for box_datapath: driver queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_box_datapath;
  localparam int FT = 4;

  logic       clock = 0;
  logic       resetn = 0;
  logic       en_dp = 0, en_vga = 0, erase = 0, can_move = 0;
  logic [2:0] colour_in = 3'b101;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, done;

  box_datapath #(
    .X_MAX(160), .Y_MAX(120), .FRAME_TICKS(FT)
  ) dut (
    .clock(clock), .resetn(resetn), .en_datapath(en_dp),
    .en_vga(en_vga), .erase(erase), .can_move(can_move),
    .colour_in(colour_in), .x(x), .y(y), .colour(colour),
    .plot(plot), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
    logic       d;
    bit         cxy;
    bit         cd;
    string      tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int ox = 0, oy = 0;
  bit mdx = 1, mdy = 1;

  task automatic cmp(input string tag, input string what,
                     input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%0d required=%0d @%0t",
               tag, what, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.cxy) begin
        cmp(e.tag, "x", x, e.x);
        cmp(e.tag, "y", {1'b0, y}, {1'b0, e.y});
        cmp(e.tag, "colour", {5'b0, colour}, {5'b0, e.c});
      end
      cmp(e.tag, "plot", {7'b0, plot}, {7'b0, e.p});
      if (e.cd) cmp(e.tag, "done", {7'b0, done}, {7'b0, e.d});
    end
  end

  task automatic drive(input bit rn, input bit dp, input bit vga,
                       input bit er, input bit cm, input bit cxy,
                       input bit cd, input int ex, input int ey,
                       input bit ed, input string tag);
    exp_t e;
    resetn = rn; en_dp = dp; en_vga = vga; erase = er; can_move = cm;
    e.x = 8'(ex); e.y = 7'(ey);
    e.c = er ? 3'b000 : colour_in;
    e.p = rn & dp & vga;
    e.d = ed; e.cxy = cxy; e.cd = cd; e.tag = tag;
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic step_model();
`ifdef BOX_DATAPATH_BOUNCE_EN
    if (mdx && ox == 156) begin mdx = 0; ox = 155; end
    else if (!mdx && ox == 0) begin mdx = 1; ox = 1; end
    else ox = mdx ? ox + 1 : ox - 1;
    if (mdy && oy == 116) begin mdy = 0; oy = 115; end
    else if (!mdy && oy == 0) begin mdy = 1; oy = 1; end
    else oy = mdy ? oy + 1 : oy - 1;
`else
    ox = (ox == 156) ? 0 : ox + 1;
    oy = (oy == 116) ? 0 : oy + 1;
`endif
  endtask

  task automatic sweep(input bit er, input int n, input string tag);
    for (int i = 0; i < n; i++)
      drive(1, 1, 1, er, 0, 1, 1, ox + i % 4, oy + i / 4, i == 15, tag);
    if (er && n == 16) step_model();
  endtask

  initial begin
    @(posedge clock);
    #1;
    // reset held with the sweep enabled: no strobe, no done
    repeat (2) drive(0, 1, 1, 0, 1, 1, 1, 0, 0, 0, "reset");
    sweep(0, 16, "draw0");
    // wait phase, can_move paused for one cycle
    drive(1, 0, 1, 0, 1, 1, 1, ox, oy, 1, "wait0");
    drive(1, 0, 0, 0, 1, 1, 1, ox, oy, 1, "wait1");
    drive(1, 0, 0, 0, 0, 1, 1, ox, oy, 1, "wait_hold");
    drive(1, 0, 0, 0, 1, 1, 1, ox, oy, 1, "wait2");
    drive(1, 0, 0, 0, 1, 1, 1, ox, oy, 0, "wait_expire");
    drive(1, 0, 0, 0, 1, 1, 1, ox, oy, 1, "wait_restart");
    sweep(1, 16, "erase0");
    sweep(0, 16, "draw11");
    // aborted erase: no step, count returns to 0
    sweep(1, 5, "erase_part");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "abort0");
    drive(1, 0, 0, 0, 0, 1, 0, ox, oy, 0, "abort1");
    sweep(1, 16, "erase11");
    // reset during a draw at count 7
    sweep(0, 7, "draw_pre_rst");
    drive(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, "mid_reset");
    ox = 0; oy = 0; mdx = 1; mdy = 1;
    sweep(0, 16, "draw_after_rst");
    // walk to the right edge and across it
    for (int k = 0; k < 157; k++) sweep(1, 16, "erase_walk");
    sweep(0, 16, "draw_edge");
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clock);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
